// File: rtl/srcsel_pkg.sv
// Shared select encodings and the stage state type for the ALU operand-select stage.
package srcsel_pkg;

  localparam int SEL_W = 2;

  localparam logic [SEL_W-1:0] SRC_A_RS1  = 2'd0;
  localparam logic [SEL_W-1:0] SRC_A_PC   = 2'd1;
  localparam logic [SEL_W-1:0] SRC_A_ZERO = 2'd2;

  localparam logic [SEL_W-1:0] SRC_B_RS2  = 2'd0;
  localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'd1;
  localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'd2;
  localparam logic [SEL_W-1:0] SRC_B_ZERO = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_e;

endpackage

// File: rtl/fwd_match.sv
// Tag compare against all writeback buses; the lowest-index matching bus supplies the data.
module fwd_match #(
  parameter int NUM_FWD  = 2,
  parameter int TAG_LEN  = 6,
  parameter int DATA_LEN = 32
) (
  input  logic [TAG_LEN-1:0]          tag,
  input  logic [NUM_FWD-1:0]          fwd_valid,
  input  logic [NUM_FWD*TAG_LEN-1:0]  fwd_tag,
  input  logic [NUM_FWD*DATA_LEN-1:0] fwd_data,
  output logic                        hit,
  output logic [DATA_LEN-1:0]         data
);

  // Scan from the top down so the last assignment, i.e. the lowest index, wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_tag[i*TAG_LEN +: TAG_LEN] == tag)) begin
        hit  = 1'b1;
        data = fwd_data[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

endmodule

// File: rtl/operand_sel_stage.sv
// Registered operand-select stage between issue and ALU: holds one instruction until its
// register operands resolve (directly or via writeback forwarding), then presents ALU src A/B.
module operand_sel_stage
  import srcsel_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int TAG_LEN  = 6,
  parameter int NUM_FWD  = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SEL_W-1:0]            src_a_sel,
  input  logic [SEL_W-1:0]            src_b_sel,
  input  logic [ADDR_LEN-1:0]         pc,
  input  logic [DATA_LEN-1:0]         imm,
  input  logic [DATA_LEN-1:0]         rs1,
  input  logic [DATA_LEN-1:0]         rs2,
  input  logic                        rs1_rdy,
  input  logic                        rs2_rdy,
  input  logic [TAG_LEN-1:0]          rs1_tag,
  input  logic [TAG_LEN-1:0]          rs2_tag,
  input  logic [NUM_FWD-1:0]          fwd_valid,
  input  logic [NUM_FWD*TAG_LEN-1:0]  fwd_tag,
  input  logic [NUM_FWD*DATA_LEN-1:0] fwd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_LEN-1:0]         alu_src_a,
  output logic [DATA_LEN-1:0]         alu_src_b,
  output state_e                      state_dbg
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high. in_ready
  // depends only on state and out_ready; out_valid and alu_src_a/b stay stable until taken.

  state_e state, next_state;

  logic [SEL_W-1:0]    sel_a_q, sel_b_q;
  logic [ADDR_LEN-1:0] pc_q;
  logic [DATA_LEN-1:0] imm_q, a_val_q, b_val_q;
  logic                a_rdy_q, b_rdy_q;
  logic [TAG_LEN-1:0]  a_tag_q, b_tag_q;
  logic [DATA_LEN-1:0] src_a_q, src_b_q;

  logic                capture, hold_update, load_out, ops_ok;
  logic [SEL_W-1:0]    cur_sel_a, cur_sel_b;
  logic [ADDR_LEN-1:0] cur_pc;
  logic [DATA_LEN-1:0] cur_imm, cur_a_val, cur_b_val;
  logic                cur_a_rdy, cur_b_rdy;
  logic [TAG_LEN-1:0]  cur_a_tag, cur_b_tag;
  logic                a_hit, b_hit;
  logic [DATA_LEN-1:0] a_fwd, b_fwd;
  logic                a_rdy_n, b_rdy_n, a_ok, b_ok;
  logic [DATA_LEN-1:0] a_val_n, b_val_n, src_a_n, src_b_n;

  assign in_ready    = (state == IDLE) || ((state == VALID) && out_ready);
  assign capture     = in_valid && in_ready;
  assign hold_update = capture || (state == WAIT);

  // The forward matchers see the incoming request on capture and the held entry otherwise.
  assign cur_sel_a = capture ? src_a_sel : sel_a_q;
  assign cur_sel_b = capture ? src_b_sel : sel_b_q;
  assign cur_pc    = capture ? pc        : pc_q;
  assign cur_imm   = capture ? imm       : imm_q;
  assign cur_a_val = capture ? rs1       : a_val_q;
  assign cur_b_val = capture ? rs2       : b_val_q;
  assign cur_a_rdy = capture ? rs1_rdy   : a_rdy_q;
  assign cur_b_rdy = capture ? rs2_rdy   : b_rdy_q;
  assign cur_a_tag = capture ? rs1_tag   : a_tag_q;
  assign cur_b_tag = capture ? rs2_tag   : b_tag_q;

  fwd_match #(
    .NUM_FWD (NUM_FWD),
    .TAG_LEN (TAG_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_fwd_a (
    .tag      (cur_a_tag),
    .fwd_valid(fwd_valid),
    .fwd_tag  (fwd_tag),
    .fwd_data (fwd_data),
    .hit      (a_hit),
    .data     (a_fwd)
  );

  fwd_match #(
    .NUM_FWD (NUM_FWD),
    .TAG_LEN (TAG_LEN),
    .DATA_LEN(DATA_LEN)
  ) u_fwd_b (
    .tag      (cur_b_tag),
    .fwd_valid(fwd_valid),
    .fwd_tag  (fwd_tag),
    .fwd_data (fwd_data),
    .hit      (b_hit),
    .data     (b_fwd)
  );

  // An operand already holding its value ignores later forwards on the same tag.
  assign a_rdy_n = cur_a_rdy || a_hit;
  assign b_rdy_n = cur_b_rdy || b_hit;
  assign a_val_n = (!cur_a_rdy && a_hit) ? a_fwd : cur_a_val;
  assign b_val_n = (!cur_b_rdy && b_hit) ? b_fwd : cur_b_val;
  assign a_ok    = (cur_sel_a != SRC_A_RS1) || a_rdy_n;
  assign b_ok    = (cur_sel_b != SRC_B_RS2) || b_rdy_n;
  assign ops_ok  = a_ok && b_ok;

  always_comb begin
    src_a_n = '0;
    case (cur_sel_a)
      SRC_A_RS1: src_a_n = a_val_n;
      SRC_A_PC:  src_a_n = DATA_LEN'(cur_pc);
      default:   src_a_n = '0;
    endcase
  end

  always_comb begin
    src_b_n = '0;
    case (cur_sel_b)
      SRC_B_RS2:  src_b_n = b_val_n;
      SRC_B_IMM:  src_b_n = cur_imm;
      SRC_B_FOUR: src_b_n = DATA_LEN'(4);
      default:    src_b_n = '0;
    endcase
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (capture) next_state = ops_ok ? VALID : WAIT;
      end
      WAIT: begin
        if (ops_ok) next_state = VALID;
      end
      VALID: begin
        if (out_ready) begin
          if (capture) next_state = ops_ok ? VALID : WAIT;
          else         next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  assign load_out = !flush && hold_update && ops_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sel_a_q <= '0;
      sel_b_q <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      a_val_q <= '0;
      b_val_q <= '0;
      a_rdy_q <= 1'b0;
      b_rdy_q <= 1'b0;
      a_tag_q <= '0;
      b_tag_q <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
    end else begin
      state <= next_state;
      if (!flush && hold_update) begin
        sel_a_q <= cur_sel_a;
        sel_b_q <= cur_sel_b;
        pc_q    <= cur_pc;
        imm_q   <= cur_imm;
        a_val_q <= a_val_n;
        b_val_q <= b_val_n;
        a_rdy_q <= a_rdy_n;
        b_rdy_q <= b_rdy_n;
        a_tag_q <= cur_a_tag;
        b_tag_q <= cur_b_tag;
      end
      if (load_out) begin
        src_a_q <= src_a_n;
        src_b_q <= src_b_n;
      end
    end
  end

  assign out_valid = (state == VALID);
  assign alu_src_a = src_a_q;
  assign alu_src_b = src_b_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_operand_sel_stage.sv
// Bench for operand_sel_stage: directed scenarios followed by a randomized run against a
// transaction-level model of the hold/forward/handshake rules.
module tb_operand_sel_stage;
  import srcsel_pkg::*;

  localparam int DL = 32;
  localparam int AL = 32;
  localparam int TL = 6;
  localparam int NF = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      src_a_sel, src_b_sel;
  logic [AL-1:0]   pc;
  logic [DL-1:0]   imm, rs1, rs2;
  logic            rs1_rdy, rs2_rdy;
  logic [TL-1:0]   rs1_tag, rs2_tag;
  logic [NF-1:0]   fwd_valid;
  logic [NF*TL-1:0] fwd_tag;
  logic [NF*DL-1:0] fwd_data;
  logic            out_valid, out_ready;
  logic [DL-1:0]   alu_src_a, alu_src_b;
  state_e          state_dbg;

  logic [TL-1:0]   ft[NF];
  logic [DL-1:0]   fd[NF];

  int n_vec  = 0;
  int n_fail = 0;
  logic [2*DL-1:0] exp_q[$];

  always_comb begin
    for (int i = 0; i < NF; i++) begin
      fwd_tag[i*TL +: TL]  = ft[i];
      fwd_data[i*DL +: DL] = fd[i];
    end
  end

  always #5 clk = ~clk;

  operand_sel_stage #(.DATA_LEN(DL), .ADDR_LEN(AL), .TAG_LEN(TL), .NUM_FWD(NF)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_a_sel(src_a_sel), .src_b_sel(src_b_sel), .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2),
    .rs1_rdy(rs1_rdy), .rs2_rdy(rs2_rdy), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
    .fwd_valid(fwd_valid), .fwd_tag(fwd_tag), .fwd_data(fwd_data), .out_valid(out_valid),
    .out_ready(out_ready), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .state_dbg(state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid = 0; out_ready = 0;
    src_a_sel = 0; src_b_sel = 0; pc = 0; imm = 0; rs1 = 0; rs2 = 0;
    rs1_rdy = 0; rs2_rdy = 0; rs1_tag = 0; rs2_tag = 0; fwd_valid = 0;
    for (int i = 0; i < NF; i++) begin ft[i] = 0; fd[i] = 0; end
  endtask

  task automatic send(input logic [1:0] sa, input logic [1:0] sb, input logic [AL-1:0] p,
                      input logic [DL-1:0] im, input logic [DL-1:0] r1, input logic r1r,
                      input logic [TL-1:0] t1, input logic [DL-1:0] r2, input logic r2r,
                      input logic [TL-1:0] t2);
    in_valid = 1; src_a_sel = sa; src_b_sel = sb; pc = p; imm = im;
    rs1 = r1; rs1_rdy = r1r; rs1_tag = t1; rs2 = r2; rs2_rdy = r2r; rs2_tag = t2;
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [DL-1:0] ref_a(input logic [1:0] s, input logic [DL-1:0] v,
                                          input logic [AL-1:0] p);
    if (s == 2'd0) return v;
    if (s == 2'd1) return DL'(p);
    return '0;
  endfunction

  function automatic logic [DL-1:0] ref_b(input logic [1:0] s, input logic [DL-1:0] v,
                                          input logic [DL-1:0] im);
    case (s)
      2'd0:    return v;
      2'd1:    return im;
      2'd2:    return 32'd4;
      default: return '0;
    endcase
  endfunction

  task automatic lookup(input logic [TL-1:0] t, output bit h, output logic [DL-1:0] d);
    h = 0; d = '0;
    for (int i = 0; i < NF; i++) begin
      if (!h && fwd_valid[i] && ft[i] == t) begin h = 1; d = fd[i]; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    repeat (3) tick();
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (alu_src_a !== '0) begin n_fail++; $display("FAIL reset_src_a: got %h want 0", alu_src_a); end
    n_vec++; if (alu_src_b !== '0) begin n_fail++; $display("FAIL reset_src_b: got %h want 0", alu_src_b); end
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    reset_n = 1;
    tick();
  endtask

  task automatic test_pc_four();
    out_ready = 1;
    send(2'd1, 2'd2, 32'h1000, 0, 0, 1, 0, 0, 1, 0);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pc4_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pc4_out_valid: got %b want 1", out_valid); end
    n_vec++; if (alu_src_a !== 32'h1000) begin n_fail++; $display("FAIL pc4_src_a: got %h want 00001000", alu_src_a); end
    n_vec++; if (alu_src_b !== 32'd4) begin n_fail++; $display("FAIL pc4_src_b: got %h want 00000004", alu_src_b); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pc4_back_idle: got %b want 0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_wait_fwd(input bit both_buses);
    logic [DL-1:0] want_a;
    want_a = both_buses ? 32'hAA : 32'h55;
    out_ready = 1;
    send(2'd0, 2'd0, 0, 0, 32'hDEAD, 0, 6'd5, 32'd7, 1, 6'd0);
    tick();
    in_valid = 0;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wait_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL wait_in_ready: got %b want 0", in_ready); end
    n_vec++; if (state_dbg !== WAIT) begin n_fail++; $display("FAIL wait_state: got %0d want %0d", state_dbg, WAIT); end
    tick();
    tick();
    fwd_valid[0] = 1; ft[0] = 6'd5; fd[0] = both_buses ? 32'hAA : 32'h55;
    if (both_buses) begin fwd_valid[1] = 1; ft[1] = 6'd5; fd[1] = 32'hBB; end
    tick();
    fwd_valid = 0;
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_out_valid: got %b want 1", out_valid); end
    n_vec++; if (alu_src_a !== want_a) begin n_fail++; $display("FAIL fwd_src_a: got %h want %h", alu_src_a, want_a); end
    n_vec++; if (alu_src_b !== 32'd7) begin n_fail++; $display("FAIL fwd_src_b: got %h want 00000007", alu_src_b); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_back_idle: got %b want 0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    send(2'd0, 2'd0, 0, 0, 32'h11, 1, 0, 32'h22, 1, 0);
    tick();
    in_valid = 0;
    for (int c = 0; c < 4; c++) begin
      n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid[%0d]: got %b want 1", c, out_valid); end
      n_vec++; if (alu_src_a !== 32'h11 || alu_src_b !== 32'h22) begin
        n_fail++; $display("FAIL stall_stable[%0d]: got %h/%h want 00000011/00000022", c, alu_src_a, alu_src_b);
      end
      n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
      tick();
    end
    out_ready = 1;
    send(2'd1, 2'd1, 32'h2000, 32'h30, 0, 0, 0, 0, 0, 0);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid: got %b want 1", out_valid); end
    n_vec++; if (alu_src_a !== 32'h2000 || alu_src_b !== 32'h30) begin
      n_fail++; $display("FAIL b2b_values: got %h/%h want 00002000/00000030", alu_src_a, alu_src_b);
    end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_back_idle: got %b want 0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_flush();
    out_ready = 1;
    send(2'd0, 2'd3, 0, 0, 0, 0, 6'd9, 0, 0, 0);
    tick();
    in_valid = 0;
    flush = 1;
    tick();
    flush = 0;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_out_valid: got %b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_wait_in_ready: got %b want 1", in_ready); end
    fwd_valid[0] = 1; ft[0] = 6'd9; fd[0] = 32'h99;
    tick();
    fwd_valid = 0;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_late_fwd: got %b want 0", out_valid); end
    out_ready = 0;
    send(2'd2, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    in_valid = 0;
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
    flush = 1;
    tick();
    flush = 0;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_out_valid: got %b want 0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    send(2'd1, 2'd1, 32'h4321, 32'h77, 0, 0, 0, 0, 0, 0);
    tick();
    in_valid = 0;
    n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_valid: got %b want 1", out_valid); end
    #2;
    reset_n = 0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (alu_src_a !== '0 || alu_src_b !== '0) begin
      n_fail++; $display("FAIL areset_outputs: got %h/%h want 0/0", alu_src_a, alu_src_b);
    end
    #3;
    reset_n = 1;
    idle_inputs();
    tick();
  endtask

  task automatic test_random(input int cycles);
    bit have = 0, done = 0, ha, hb, cap, hs, exp_ir;
    logic [1:0] m_sa = 0, m_sb = 0;
    logic [AL-1:0] m_pc = 0;
    logic [DL-1:0] m_imm = 0, m_av = 0, m_bv = 0, da, db;
    bit m_aok = 0, m_bok = 0;
    logic [TL-1:0] m_at = 0, m_bt = 0;
    exp_q.delete();
    for (int c = 0; c < cycles; c++) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      src_a_sel = 2'($urandom_range(0, 3));
      src_b_sel = 2'($urandom_range(0, 3));
      pc = $urandom; imm = $urandom; rs1 = $urandom; rs2 = $urandom;
      rs1_rdy = $urandom_range(0, 1); rs2_rdy = $urandom_range(0, 1);
      rs1_tag = TL'($urandom_range(0, 7)); rs2_tag = TL'($urandom_range(0, 7));
      for (int i = 0; i < NF; i++) begin
        fwd_valid[i] = ($urandom_range(0, 2) == 0);
        ft[i] = TL'($urandom_range(0, 7));
        fd[i] = $urandom;
      end
      #1;
      exp_ir = !have || (done && out_ready);
      n_vec++; if (in_ready !== exp_ir) begin n_fail++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", c, in_ready, exp_ir); end
      cap = in_valid && exp_ir;
      hs  = have && done && out_ready;
      if (flush) begin
        have = 0; done = 0; exp_q.delete();
      end else begin
        if (hs) begin void'(exp_q.pop_front()); have = 0; done = 0; end
        if (cap) begin
          m_sa = src_a_sel; m_sb = src_b_sel; m_pc = pc; m_imm = imm;
          m_av = rs1; m_bv = rs2; m_at = rs1_tag; m_bt = rs2_tag;
          m_aok = (src_a_sel != 2'd0) || rs1_rdy;
          m_bok = (src_b_sel != 2'd0) || rs2_rdy;
          have = 1; done = 0;
        end
        if (have && !done) begin
          lookup(m_at, ha, da);
          lookup(m_bt, hb, db);
          if (!m_aok && ha) begin m_aok = 1; m_av = da; end
          if (!m_bok && hb) begin m_bok = 1; m_bv = db; end
          if (m_aok && m_bok) begin
            done = 1;
            exp_q.push_back({ref_a(m_sa, m_av, m_pc), ref_b(m_sb, m_bv, m_imm)});
          end
        end
      end
      tick();
      n_vec++; if (out_valid !== (have && done)) begin
        n_fail++; $display("FAIL rnd_out_valid[%0d]: got %b want %b", c, out_valid, have && done);
      end
      if (have && done && exp_q.size() > 0) begin
        n_vec++; if ({alu_src_a, alu_src_b} !== exp_q[0]) begin
          n_fail++; $display("FAIL rnd_operands[%0d]: got %h/%h want %h/%h", c, alu_src_a, alu_src_b,
                             exp_q[0][2*DL-1:DL], exp_q[0][DL-1:0]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_pc_four();
    test_wait_fwd(1'b0);
    test_wait_fwd(1'b1);
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random(1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
